// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank: read-FSM encoding,
// default geometry and the event-strobe index map used by the core.
// Optional feature macro: PERF_CNT_SAT_EN (saturating counters with sticky overflow).
package perf_pkg;

  // Read FSM state encoding
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RESP = 1'b1;

  // Default bank geometry
  localparam int PERF_N_CNT = 16;
  localparam int PERF_CNT_W = 64;

  // Event strobe positions in the evt vector as wired by the core
  localparam int EVT_CYCLE    = 0;
  localparam int EVT_INST     = 1;
  localparam int EVT_LOAD     = 2;
  localparam int EVT_STORE    = 3;
  localparam int EVT_IF_STALL = 4;
  localparam int EVT_LD_STALL = 5;
  localparam int EVT_BR       = 6;
  localparam int EVT_BR_MISS  = 7;

endpackage

// File: rtl/perf_cnt_slice.sv
// One performance counter: increments on an unfrozen event strobe, clear has priority.
// Latency: new value registered at the edge after the strobe.
// PERF_CNT_SAT_EN: saturate at all-ones and raise sticky ovf; otherwise wrap and ovf=0.
module perf_cnt_slice #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             freeze,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic inc;
  assign inc = evt & ~freeze;

`ifdef PERF_CNT_SAT_EN
  logic at_max;
  assign at_max = &cnt;

  // Saturating count; the first increment refused at all-ones latches ovf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (at_max) ovf <= 1'b1;
      else        cnt <= cnt + CNT_W'(1);
    end
  end
`else
  // Free-running count, wraps modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/perf_cnt_bank.sv
// Bank of N_CNT event counters read one 32-bit word at a time with a coherent lo/hi snapshot.
// Latency: response valid 1 cycle after the request handshake; one read per 2 cycles max.
// Backpressure: rd_data held and requests refused until rd_resp_ready. Macro: PERF_CNT_SAT_EN.
module perf_cnt_bank
  import perf_pkg::*;
#(
  parameter int N_CNT = PERF_N_CNT,
  parameter int CNT_W = PERF_CNT_W,
  parameter int IDX_W = $clog2(N_CNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CNT-1:0] evt,
  input  logic             freeze,
  input  logic             clr,
  input  logic [N_CNT-1:0] clr_mask,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_hi,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic [31:0]      rd_data,
  output logic [N_CNT-1:0] ovf
);

  logic [CNT_W-1:0] cnt [N_CNT];
  logic [0:0]       state;
  logic [CNT_W-1:0] snap;
  logic [IDX_W-1:0] snap_idx;
  logic             snap_v;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_hit;
  logic             snap_match;
  logic             req_fire;
  logic             resp_fire;
  logic [31:0]      rd_word;

  for (genvar k = 0; k < N_CNT; k++) begin : g_slice
    perf_cnt_slice #(.CNT_W(CNT_W)) u_slice (
      .clk    (clk),
      .rst    (rst),
      .evt    (evt[k]),
      .freeze (freeze),
      .clr    (clr & clr_mask[k]),
      .cnt    (cnt[k]),
      .ovf    (ovf[k])
    );
  end

  assign rd_req_ready  = (state == RD_IDLE);
  assign rd_resp_valid = (state == RD_RESP);
  assign req_fire      = rd_req_valid & rd_req_ready;
  assign resp_fire     = rd_resp_valid & rd_resp_ready;
  assign snap_match    = snap_v && (snap_idx == rd_idx);

  // Counter select; an index past the last counter selects nothing
  always_comb begin
    sel_cnt = '0;
    sel_hit = 1'b0;
    for (int k = 0; k < N_CNT; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        sel_cnt = cnt[k];
        sel_hit = 1'b1;
      end
    end
  end

  // Word to return: low word live, high word from snapshot when it belongs to this index
  always_comb begin
    rd_word = '0;
    if (sel_hit) begin
      if (!rd_hi)          rd_word = sel_cnt[31:0];
      else if (snap_match) rd_word = 32'(snap >> 32);
      else                 rd_word = 32'(sel_cnt >> 32);
    end
  end

  // Read FSM: IDLE accepts a request, RESP holds the answer until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RD_IDLE;
    end else begin
      case (state)
        RD_IDLE: if (req_fire)  state <= RD_RESP;
        RD_RESP: if (resp_fire) state <= RD_IDLE;
        default: state <= RD_IDLE;
      endcase
    end
  end

  // Response data and snapshot; a new low read overrides a same-cycle clear of the old snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      snap     <= '0;
      snap_idx <= '0;
      snap_v   <= 1'b0;
    end else begin
      if (clr && clr_mask[snap_idx]) snap_v <= 1'b0;
      if (req_fire) begin
        rd_data <= rd_word;
        if (sel_hit) begin
          if (!rd_hi) begin
            snap     <= sel_cnt;
            snap_idx <= rd_idx;
            snap_v   <= 1'b1;
          end else if (snap_match) begin
            snap_v <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Bench for perf_cnt_bank: a 12x64 bank and a 12x32 bank share the read request channel.
// Expected read words are queued when each request is issued and compared on response.
// Overflow expectations follow PERF_CNT_SAT_EN as compiled.
module tb_perf_cnt_bank;
  import perf_pkg::*;

`ifdef PERF_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] evt, clr_mask, evt32, clr_mask32;
  logic        freeze, clr, freeze32, clr32;
  logic        rd_req_valid, rd_hi, rd_resp_ready;
  logic [3:0]  rd_idx;
  logic        rd_req_ready, rd_resp_valid, rd_req_ready32, rd_resp_valid32;
  logic [31:0] rd_data, rd_data32;
  logic [11:0] ovf, ovf32;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp32_q[$];
  string       tag_q[$];

  perf_cnt_bank #(.N_CNT(12), .CNT_W(64), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .evt(evt), .freeze(freeze), .clr(clr), .clr_mask(clr_mask),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_idx(rd_idx), .rd_hi(rd_hi),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_data(rd_data), .ovf(ovf)
  );

  perf_cnt_bank #(.N_CNT(12), .CNT_W(32), .IDX_W(4)) dut32 (
    .clk(clk), .rst(rst), .evt(evt32), .freeze(freeze32), .clr(clr32), .clr_mask(clr_mask32),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready32), .rd_idx(rd_idx), .rd_hi(rd_hi),
    .rd_resp_valid(rd_resp_valid32), .rd_resp_ready(rd_resp_ready), .rd_data(rd_data32),
    .ovf(ovf32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Response scoreboards
  always @(negedge clk) begin
    if (rd_resp_valid && rd_resp_ready) begin
      check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check(tag_q.pop_front(), rd_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rd_resp_valid32 && rd_resp_ready) begin
      check("resp32_expected", 64'(exp32_q.size() != 0), 64'd1);
      if (exp32_q.size() != 0) check("d32_data", rd_data32, exp32_q.pop_front());
    end
  end

  // One read through both banks; e is the 64-bit bank answer, e32 the 32-bit bank answer
  task automatic rd(input string tag, input int idx, input bit hi,
                    input logic [31:0] e, input logic [31:0] e32);
    bit done;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    exp32_q.push_back(e32);
    tick();
    rd_req_valid = 1'b1;
    rd_idx       = 4'(idx);
    rd_hi        = hi;
    tick();
    rd_req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat"}, rd_resp_valid, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!rd_resp_valid) done = 1'b1;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic pulse_evt(input int idx, input int cycles);
    tick();
    evt[idx] = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    evt = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    evt = '0; clr_mask = '0; evt32 = '0; clr_mask32 = '0;
    freeze = 1'b0; clr = 1'b0; freeze32 = 1'b0; clr32 = 1'b0;
    rd_req_valid = 1'b0; rd_hi = 1'b0; rd_idx = '0; rd_resp_ready = 1'b1;
    #3;
    check("rst_req_ready", rd_req_ready, 1'b1);
    check("rst_resp_valid", rd_resp_valid, 1'b0);
    check("rst_data", rd_data, 32'd0);
    check("rst_ovf", ovf, 12'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic count
    pulse_evt(EVT_STORE, 10);
    rd("basic_lo", 3, 1'b0, 32'd10, 32'd0);
    rd("basic_hi", 3, 1'b1, 32'd0, 32'd0);

    // Freeze, then clear beats a simultaneous increment
    tick();
    freeze = 1'b1;
    evt[EVT_INST] = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    freeze = 1'b0;
    evt = '0;
    rd("frz", 1, 1'b0, 32'd0, 32'd0);
    pulse_evt(EVT_INST, 3);
    rd("cnt1", 1, 1'b0, 32'd3, 32'd0);
    tick();
    evt = 12'h006;
    clr = 1'b1;
    clr_mask = 12'h002;
    tick();
    evt = '0; clr = 1'b0; clr_mask = '0;
    rd("clr_win", 1, 1'b0, 32'd0, 32'd0);
    rd("clr_other", 2, 1'b0, 32'd1, 32'd0);

    // Snapshot coherence across a carry into the high word
    @(negedge clk);
    force dut.g_slice[0].u_slice.cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.g_slice[0].u_slice.cnt;
    rd("snap_lo", 0, 1'b0, 32'hFFFF_FFFF, 32'd0);
    pulse_evt(EVT_CYCLE, 2);
    rd("snap_hi", 0, 1'b1, 32'd0, 32'd0);
    rd("live_hi", 0, 1'b1, 32'd1, 32'd0);
    rd("live_lo", 0, 1'b0, 32'd1, 32'd0);
    rd("other_lo", 3, 1'b0, 32'd10, 32'd0);
    rd("idx_mis_hi", 0, 1'b1, 32'd1, 32'd0);
    rd("pre_clr_lo", 0, 1'b0, 32'd1, 32'd0);
    tick();
    clr = 1'b1;
    clr_mask = 12'h001;
    tick();
    clr = 1'b0; clr_mask = '0;
    rd("clr_snap_hi", 0, 1'b1, 32'd0, 32'd0);
    check("ovf_main", ovf, 12'd0);

    // Backpressure
    rd_resp_ready = 1'b0;
    exp_q.push_back(32'd10);
    tag_q.push_back("bp");
    exp32_q.push_back(32'd0);
    tick();
    rd_req_valid = 1'b1; rd_idx = 4'd3; rd_hi = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", rd_resp_valid, 1'b1);
      check("bp_data", rd_data, 32'd10);
      check("bp_req_ready", rd_req_ready, 1'b0);
    end
    tick();
    rd_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle", rd_req_ready, 1'b1);
    check("bp_valid_low", rd_resp_valid, 1'b0);
    check("bp_one_resp", 64'(exp_q.size()), 64'd0);

    // Overflow on the 32-bit bank
    @(negedge clk);
    force dut32.g_slice[2].u_slice.cnt = 32'hFFFF_FFFF;
    #1;
    release dut32.g_slice[2].u_slice.cnt;
    rd("ovf_hi32", 2, 1'b1, 32'd0, 32'd0);
    tick(); evt32[2] = 1'b1; tick(); evt32 = '0;
    rd("ovf_lo", 2, 1'b0, 32'd1, SAT ? 32'hFFFF_FFFF : 32'd0);
    check("ovf_flag", ovf32, SAT ? 12'h004 : 12'h000);
    tick(); evt32[2] = 1'b1; tick(); evt32 = '0;
    rd("ovf_lo2", 2, 1'b0, 32'd1, SAT ? 32'hFFFF_FFFF : 32'd1);
    check("ovf_sticky", ovf32, SAT ? 12'h004 : 12'h000);
    tick(); clr32 = 1'b1; clr_mask32 = 12'h004; tick(); clr32 = 1'b0; clr_mask32 = '0;
    rd("ovf_clr", 2, 1'b0, 32'd1, 32'd0);
    check("ovf_cleared", ovf32, 12'h000);

    // Reset in the middle of a pending response
    rd_resp_ready = 1'b0;
    tick();
    rd_req_valid = 1'b1; rd_idx = 4'd3; rd_hi = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    check("mid_valid", rd_resp_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", rd_resp_valid, 1'b0);
    check("rst_mid_valid32", rd_resp_valid32, 1'b0);
    check("rst_mid_req_ready", rd_req_ready, 1'b1);
    check("rst_mid_data", rd_data, 32'd0);
    exp_q.delete();
    tag_q.delete();
    exp32_q.delete();
    @(negedge clk);
    rst = 1'b1;
    rd_resp_ready = 1'b1;
    rd("rst_c3", 3, 1'b0, 32'd0, 32'd0);
    rd("rst_c2", 2, 1'b0, 32'd0, 32'd0);
    tick();
    evt = 12'hFFF;
    repeat (3) @(posedge clk);
    #2;
    evt = '0;
    rd("all_c11", 11, 1'b0, 32'd3, 32'd0);
    rd("oor_lo", 14, 1'b0, 32'd0, 32'd0);
    rd("oor_hi", 13, 1'b1, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_cnt_bank.md
# perf_cnt_bank

Parametrised performance-counter bank for the custom CPU cores. It replaces the fixed set of sixteen 32-bit, hand-wired `cpu_perf_cnt_*` outputs with N_CNT generic counters of CNT_W bits each. Counters are driven by one-cycle event strobes from the core. They support masked clear and global freeze, and are read one 32-bit word at a time over a valid/ready request/response channel, with a coherent snapshot so the high word always matches the previously read low word.

## Interface
Parameters:
- N_CNT, default 16: number of counters, 2..32.
- CNT_W, default 64: counter width, 32..64.
- IDX_W, default $clog2(N_CNT): counter index width.

Ports:
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- evt  in  N_CNT  per-counter increment strobe, one increment per cycle high.
- freeze  in  1  when 1, all increments are suppressed.
- clr  in  1  clear strobe, applied to the counters selected by clr_mask.
- clr_mask  in  N_CNT  counters cleared when clr=1.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request ready.
- rd_idx  in  IDX_W  counter index.
- rd_hi  in  1  0 selects bits 31:0, 1 selects bits CNT_W-1:32 (zero-extended).
- rd_resp_valid  out  1  read data valid.
- rd_resp_ready  in  1  read data accepted.
- rd_data  out  32  read data.
- ovf  out  N_CNT  sticky overflow flags (PERF_CNT_SAT_EN only; otherwise tied 0).

## Operation
- **Reset:**
  - All counters, snapshot register and ovf are 0.
  - rd_req_ready=1, rd_resp_valid=0, rd_data=0.
  - Read FSM is in IDLE.
- **Increment:** counter k += 1 when evt[k] & ~freeze.
- **Clear:** clr & clr_mask[k] forces counter k (and ovf[k]) to 0 that cycle. Clear wins over a simultaneous increment.
- **Read FSM:** two states, IDLE and RESP.
  - IDLE: rd_req_ready=1. A handshake (rd_req_valid & rd_req_ready) captures rd_data and moves to RESP.
  - RESP: rd_req_ready=0, rd_resp_valid=1. rd_data is held stable until rd_resp_ready, then the FSM returns to IDLE.
- **Low-word read (rd_hi=0):** returns counter[31:0] and latches the full CNT_W-bit value into snap, and rd_idx into snap_idx, setting snap_v=1.
- **High-word read (rd_hi=1):**
  - If snap_v and snap_idx==rd_idx: returns snap[CNT_W-1:32]; snap_v is cleared.
  - Otherwise: returns the live high bits.
  - CNT_W=32: always returns 0.
- **Out-of-range index:** rd_idx ≥ N_CNT returns 0; the snapshot is not touched.
- **Read/update ordering:** a read returns the registered value before any same-cycle increment or clear.
- **Clearing the snapshotted counter:** a clear of counter snap_idx also clears snap_v.

## Timing
- Request-to-response latency is 1 cycle: rd_resp_valid rises the cycle after the request handshake.
- Maximum throughput is one read per 2 cycles.
- Increment and clear take effect at the clock edge after the strobe; the new value is visible to a read one cycle later.
- Wrap (macro off): all-ones + 1 gives 0 with no indication.
- Reset asserted mid-transaction drops any pending response immediately: rd_resp_valid goes to 0 asynchronously.

## Configuration
- PERF_CNT_SAT_EN defined:
  - A counter at all-ones stays at all-ones on further events.
  - ovf[k] sets on the first suppressed increment and stays set until clr with clr_mask[k] or reset.
- PERF_CNT_SAT_EN undefined:
  - Counters wrap modulo 2^CNT_W.
  - ovf is constant 0 and no saturation logic is synthesised.

## Structure
- Package perf_pkg holds:
  - the read-FSM state encoding (IDLE/RESP localparams);
  - default N_CNT/CNT_W constants;
  - the event-index constants used by the core (CYCLE=0, INST=1, LOAD=2, STORE=3, IF_STALL=4, …).
- Sub-module perf_cnt_slice:
  - one counter with inputs evt, freeze, clr, plus the saturation/ovf logic under the macro;
  - instantiated N_CNT times in a generate loop;
  - read mux, snapshot and FSM stay at the top level.

## Test plan
- **Reset and basic count:** reset, then evt[3] held high 10 cycles, freeze=0. Read idx 3 low → 10; read idx 3 high → 0.
- **Freeze and clear priority:** evt[1] high 5 cycles with freeze=1 → counter 1 stays 0. Then clr=1, clr_mask[1]=1 in the same cycle as evt[1]=1 → counter 1 = 0.
- **Snapshot coherence:**
  - Force counter 0 to 0x0000_0000_FFFF_FFFF.
  - Read low → 0xFFFF_FFFF.
  - Keep evt[0] high for 2 cycles, then read high → 0x0000_0000 (snapshot), not the live 1.
  - A second high read → the live value, 1.
- **Backpressure:** issue a read with rd_resp_ready=0 for 4 cycles → rd_resp_valid and rd_data stable, rd_req_ready=0 throughout. Release → one handshake, FSM back in IDLE next cycle.
- **Overflow:**
  - CNT_W=32, counter at 0xFFFF_FFFF, one event.
  - With PERF_CNT_SAT_EN: value 0xFFFF_FFFF, ovf[k]=1 until cleared.
  - Without the macro: value 0, ovf=0.
- **Reset mid-read:** assert rst while in RESP → rd_resp_valid=0 immediately, all counters 0. After release: rd_req_ready=1, and an out-of-range index read returns 0.
